psec6_readout_seq: RTL and testbench

//  Readout sequencer downstream of the SPI config block. On the readout instruction

---
 rtl/psec6_readout_seq.sv | 182 ++++++++++++++++++
 tb/tb_psec6_readout_seq.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/psec6_readout_seq.sv
// psec6_readout_seq: walks enabled channels/counter selects, settles the mux,
// captures each counter word and shifts it out MSB first. Option: PSEC6_RO_PARITY_EN.
module psec6_readout_seq #(
    parameter int NUM_CH     = 8,
    parameter int NUM_SEL    = 5,
    parameter int DATA_W     = 12,
    parameter int SETTLE_CYC = 2
) (
    input  logic              spi_clk,
    input  logic              rstn,
    input  logic              inst_readout,
    input  logic              inst_rst,
    input  logic [NUM_CH-1:0] ch_mask,
    input  logic [DATA_W-1:0] ch_data,
    output logic [2:0]        ch_sel,
    output logic [2:0]        cnt_sel,
    output logic              ro_data,
    output logic              ro_valid,
    output logic              ro_frame,
    output logic              busy,
    output logic              ro_done
);

    localparam int IDX_W = $clog2(NUM_CH + 1);
    localparam int CYC_W = $clog2(DATA_W + SETTLE_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SCAN, S_SETTLE, S_SHIFT, S_PARITY, S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic                prev_q;
    logic [NUM_CH-1:0]   mask_q;
    logic [IDX_W-1:0]    idx_q;
    logic [2:0]          sel_q;
    logic [2:0]          ch_sel_q, cnt_sel_q;
    logic [CYC_W-1:0]    cyc_q;
    logic [DATA_W-1:0]   shreg_q;
`ifdef PSEC6_RO_PARITY_EN
    logic                par_q;
`endif

    logic                rise;
    logic                hit;
    logic [2:0]          hit_ch;
    logic                settle_last;
    logic                shift_last;

    assign rise        = inst_readout & ~prev_q;
    assign settle_last = (cyc_q == CYC_W'(SETTLE_CYC - 1));
    assign shift_last  = (cyc_q == CYC_W'(DATA_W - 1));

    // Lowest enabled channel at or above the current scan index
    always_comb begin
        hit    = 1'b0;
        hit_ch = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask_q[i] && (IDX_W'(i) >= idx_q)) begin
                hit    = 1'b1;
                hit_ch = 3'(i);
            end
        end
    end

    // State register
    always_ff @(posedge spi_clk or negedge rstn) begin
        if (!rstn) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; the reset instruction overrides everything
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (rise) state_d = S_SCAN;
            S_SCAN:   state_d = hit ? S_SETTLE : S_DONE;
            S_SETTLE: if (settle_last) state_d = S_SHIFT;
`ifdef PSEC6_RO_PARITY_EN
            S_SHIFT:  if (shift_last) state_d = S_PARITY;
            S_PARITY: state_d = S_SCAN;
`else
            S_SHIFT:  if (shift_last) state_d = S_SCAN;
`endif
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        if (inst_rst) state_d = S_IDLE;
    end

    // Datapath: edge detect, mask latch, scan index, selects, shift register
    always_ff @(posedge spi_clk or negedge rstn) begin
        if (!rstn) begin
            prev_q    <= 1'b0;
            mask_q    <= '0;
            idx_q     <= '0;
            sel_q     <= '0;
            ch_sel_q  <= '0;
            cnt_sel_q <= '0;
            cyc_q     <= '0;
            shreg_q   <= '0;
`ifdef PSEC6_RO_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            prev_q <= inst_readout;
            if (inst_rst) begin
                idx_q     <= '0;
                sel_q     <= '0;
                ch_sel_q  <= '0;
                cnt_sel_q <= '0;
                cyc_q     <= '0;
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        if (rise) begin
                            mask_q <= ch_mask;
                            idx_q  <= '0;
                            sel_q  <= '0;
                        end
                    end
                    S_SCAN: begin
                        cyc_q <= '0;
                        if (hit) begin
                            ch_sel_q  <= hit_ch;
                            cnt_sel_q <= sel_q;
                            idx_q     <= IDX_W'(hit_ch);
                        end
                    end
                    S_SETTLE: begin
                        if (settle_last) begin
                            cyc_q   <= '0;
                            shreg_q <= ch_data;
`ifdef PSEC6_RO_PARITY_EN
                            par_q   <= ^ch_data;
`endif
                        end else begin
                            cyc_q <= cyc_q + 1'b1;
                        end
                    end
                    S_SHIFT: begin
                        shreg_q <= {shreg_q[DATA_W-2:0], 1'b0};
                        if (shift_last) begin
                            cyc_q <= '0;
                            if (sel_q == 3'(NUM_SEL - 1)) begin
                                sel_q <= '0;
                                idx_q <= idx_q + 1'b1;
                            end else begin
                                sel_q <= sel_q + 1'b1;
                            end
                        end else begin
                            cyc_q <= cyc_q + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Outputs decoded from the current state
    always_comb begin
        ch_sel   = ch_sel_q;
        cnt_sel  = cnt_sel_q;
        busy     = (state_q != S_IDLE);
        ro_done  = (state_q == S_DONE);
        ro_valid = 1'b0;
        ro_frame = 1'b0;
        ro_data  = 1'b0;
        if (state_q == S_SHIFT) begin
            ro_valid = 1'b1;
            ro_frame = (cyc_q == '0);
            ro_data  = shreg_q[DATA_W-1];
        end
`ifdef PSEC6_RO_PARITY_EN
        if (state_q == S_PARITY) begin
            ro_valid = 1'b1;
            ro_data  = par_q;
        end
`endif
    end

endmodule

// File: tb/tb_psec6_readout_seq.sv
// Testbench for psec6_readout_seq: randomized channel data and masks checked
// against a word-list model built from the scan order and timing rules.
module tb_psec6_readout_seq;

    localparam int NUM_CH = 8;
    localparam int NUM_SEL = 5;
    localparam int DATA_W = 12;
    localparam int SETTLE = 2;
`ifdef PSEC6_RO_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int PER = 1 + SETTLE + DATA_W + PAR;

    logic              spi_clk;
    logic              rstn;
    logic              inst_readout;
    logic              inst_rst;
    logic [NUM_CH-1:0] ch_mask;
    logic [DATA_W-1:0] ch_data;
    logic [2:0]        ch_sel;
    logic [2:0]        cnt_sel;
    logic              ro_data;
    logic              ro_valid;
    logic              ro_frame;
    logic              busy;
    logic              ro_done;

    logic [DATA_W-1:0] mem [64];
    logic [DATA_W-1:0] noise;

    int total;
    int passed;
    int fails;
    int cyc;
    bit glitch;

    typedef struct {
        int ch;
        int sel;
        int data;
    } word_t;
    word_t exp_q[$];

    psec6_readout_seq #(
        .NUM_CH(NUM_CH), .NUM_SEL(NUM_SEL),
        .DATA_W(DATA_W), .SETTLE_CYC(SETTLE)
    ) dut (
        .spi_clk(spi_clk), .rstn(rstn),
        .inst_readout(inst_readout), .inst_rst(inst_rst),
        .ch_mask(ch_mask), .ch_data(ch_data),
        .ch_sel(ch_sel), .cnt_sel(cnt_sel),
        .ro_data(ro_data), .ro_valid(ro_valid), .ro_frame(ro_frame),
        .busy(busy), .ro_done(ro_done)
    );

    initial spi_clk = 1'b0;
    always #5 spi_clk = ~spi_clk;

    // Mux model; garbage on the bus while bits are streaming out
    always_comb ch_data = ro_valid ? noise : mem[{ch_sel, cnt_sel}];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge spi_clk);
        #1;
        cyc++;
        noise = DATA_W'($urandom);
        if (glitch) begin
            if (cyc == 20) inst_readout = 1'b0;
            if (cyc == 30) inst_readout = 1'b1;
        end
    endtask

    function automatic void build(input logic [NUM_CH-1:0] m);
        word_t w;
        exp_q.delete();
        for (int c = 0; c < NUM_CH; c++) begin
            if (m[c]) begin
                for (int s = 0; s < NUM_SEL; s++) begin
                    w.ch = c;
                    w.sel = s;
                    w.data = int'(mem[c * 8 + s]);
                    exp_q.push_back(w);
                end
            end
        end
    endfunction

    task automatic randomize_mem();
        for (int i = 0; i < 64; i++) mem[i] = DATA_W'($urandom);
    endtask

    task automatic run(input logic [NUM_CH-1:0] m, input bit glt,
                       input string tag);
        word_t e;
        int nw;
        int widx;
        int done_cnt;
        int done_cyc;
        int stray;
        int w;
        bit ok;
        build(m);
        nw = exp_q.size();
        widx = 0;
        done_cnt = 0;
        done_cyc = -1;
        stray = 0;
        glitch = 1'b0;
        inst_readout = 1'b0;
        ch_mask = m;
        tick();
        inst_readout = 1'b1;
        cyc = 0;
        glitch = glt;
        tick();
        chk({tag, " busy@N+1"}, 32'(busy), 32'd1);
        while (cyc <= 2 + nw * PER + 10) begin
            if (ro_frame) begin
                chk({tag, " frame_cyc"}, cyc, 4 + widx * PER);
                if (widx < nw) e = exp_q[widx];
                else e = '{-1, -1, -1};
                chk({tag, " ch_sel"}, 32'(ch_sel), e.ch);
                chk({tag, " cnt_sel"}, 32'(cnt_sel), e.sel);
                w = 0;
                ok = 1'b1;
                for (int b = 0; b < DATA_W; b++) begin
                    w = (w << 1) | int'(ro_data);
                    if (ro_valid !== 1'b1) ok = 1'b0;
                    if (ro_frame !== (b == 0)) ok = 1'b0;
                    if (b < DATA_W - 1) tick();
                end
                chk({tag, " word"}, w, e.data);
                if (PAR != 0) begin
                    tick();
                    if (ro_valid !== 1'b1 || ro_frame !== 1'b0) ok = 1'b0;
                    chk({tag, " parity"}, 32'(ro_data),
                        $countones(e.data) % 2);
                end
                chk({tag, " valid/frame shape"}, 32'(ok), 32'd1);
                widx++;
            end else if (ro_valid) begin
                stray++;
            end
            if (ro_done) begin
                done_cnt++;
                done_cyc = cyc;
                tick();
                chk({tag, " busy after done"}, 32'(busy), 32'd0);
                chk({tag, " done pulse width"}, 32'(ro_done), 32'd0);
                break;
            end
            tick();
        end
        chk({tag, " words"}, widx, nw);
        chk({tag, " done count"}, done_cnt, 1);
        chk({tag, " done cycle"}, done_cyc, 2 + nw * PER);
        chk({tag, " stray valid"}, stray, 0);
        glitch = 1'b0;
        inst_readout = 1'b0;
        tick();
        tick();
        chk({tag, " stays idle"}, 32'(busy), 32'd0);
    endtask

    task automatic abort_run(input logic [NUM_CH-1:0] m);
        int seen;
        inst_readout = 1'b0;
        ch_mask = m;
        tick();
        inst_readout = 1'b1;
        cyc = 0;
        while (cyc < 4 + 2 * PER + 4) tick();
        chk("abort pre valid", 32'(ro_valid), 32'd1);
        chk("abort pre frame", 32'(ro_frame), 32'd0);
        inst_rst = 1'b1;
        tick();
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort valid", 32'(ro_valid), 32'd0);
        chk("abort frame", 32'(ro_frame), 32'd0);
        chk("abort ch_sel", 32'(ch_sel), 32'd0);
        chk("abort cnt_sel", 32'(cnt_sel), 32'd0);
        chk("abort done", 32'(ro_done), 32'd0);
        inst_rst = 1'b0;
        inst_readout = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (ro_done || busy || ro_valid) seen++;
        end
        chk("abort quiet", seen, 0);
    endtask

    initial begin
        total = 0;
        passed = 0;
        fails = 0;
        cyc = 0;
        glitch = 1'b0;
        noise = '0;
        rstn = 1'b0;
        inst_readout = 1'b0;
        inst_rst = 1'b0;
        ch_mask = '0;
        for (int i = 0; i < 64; i++) mem[i] = 12'hA5C;
        tick();
        tick();
        chk("reset outputs",
            {20'd0, ch_sel, cnt_sel, ro_data, ro_valid, ro_frame,
             busy, ro_done}, 32'd0);
        rstn = 1'b1;
        tick();
        chk("post reset idle", 32'(busy), 32'd0);

        run(8'h01, 1'b0, "a5c");
        for (int s = 0; s < NUM_SEL; s++) mem[s] = 12'hA5D;
        run(8'h01, 1'b0, "a5d");

        randomize_mem();
        run(8'h00, 1'b0, "mask0");
        run(8'h81, 1'b0, "mask81");
        run(8'hFF, 1'b0, "maskff");
        for (int r = 0; r < 3; r++) begin
            randomize_mem();
            run(NUM_CH'($urandom), 1'b0, "rand");
        end
        run(8'h26, 1'b1, "rerise");

        abort_run(8'h0C);
        run(8'h0C, 1'b0, "restart");

        inst_readout = 1'b0;
        tick();
        inst_readout = 1'b1;
        inst_rst = 1'b1;
        tick();
        chk("rst beats rise", 32'(busy), 32'd0);
        inst_rst = 1'b0;
        tick();
        chk("no late start", 32'(busy), 32'd0);
        inst_readout = 1'b0;
        tick();

        randomize_mem();
        run(NUM_CH'($urandom) | 8'h10, 1'b0, "final");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
